seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
- Downstream of the multi-cycle CPU's display path: consumes the CPU's 16-bit `disp_num`, plus decimal-point and status controls.
- Time-multiplexes the value onto a 4-digit common-anode 7-segment display.
- Drives the board-level `segment`/`anode` pins.
- Adds a load-strobe shadow register, glitch-free digit switching, leading-zero blanking and a blink mode used to flag CPU `finish`.

Parameters:
- SCAN_CNT, 50000: clk cycles each digit stays selected. Must be ≥2.
- BLINK_ROUNDS, 64: full 4-digit scan rounds per blink half-period. Must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- disp_num  in  16  value to display: nibble k drives digit k; digit 0 is rightmost.
- load  in  1  single-cycle strobe; captures disp_num, blank_lz and dp_in.
- blank_lz  in  1  leading-zero blanking enable.
- dp_in  in  4  decimal point per digit, active-high.
- blink_en  in  1  blink whole display, level-sensitive.
- segment  out  8  {dp,g,f,e,d,c,b,a}, active-low, registered.
- anode  out  4  digit enables, active-low, registered; anode[k] selects digit k.
- active  out  1  1 once state is RUN.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: segment=8'hFF, anode=4'hF, active=0.
  - Internal: shadow value=0, shadow dp=0, shadow blank_lz=0, prescaler=0, idx=3, round count=0, blink phase=0, state=OFF.
- State machine, two states OFF and RUN:
  - OFF: outputs held blank, prescaler idle.
  - OFF → RUN on the edge where load=1. That edge captures the shadows, clears the prescaler, sets idx=3 and sets active=1.
  - No RUN → OFF transition except reset.
- Prescaler (RUN only):
  - Counts 0..SCAN_CNT-1 and wraps to 0.
  - tick = (prescaler == SCAN_CNT-1).
- On tick:
  - idx ← (idx+1) mod 4.
  - segment and anode are registered for the new idx on that same edge.
  - Between ticks, outputs hold and never change.
  - First visible digit is digit 0, appearing SCAN_CNT cycles after the load edge.
- Load while in RUN:
  - Shadows update on the load edge.
  - New content appears only at the next tick; the current digit is never altered mid-slot.
  - load=1 on a tick edge: the tick decodes the newly loaded value.
- Digit decode for digit k, nibble n = shadow[4k+3:4k], active-low {g..a}:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
  - segment[7] = ~dp[k].
  - Full bytes with dp off: 0=C0, 1=F9, 2=A4, A=88, F=8E.
- Leading-zero blanking:
  - Applies when shadow blank_lz=1, k≠0 and every nibble at positions ≥k is 0.
  - Blanked digit: anode=4'hF, segment=8'hFF for that slot.
  - Digit 0 is never blanked.
- Blink:
  - Round count increments on each tick where idx wraps 3→0.
  - When round count reaches BLINK_ROUNDS-1 and wraps, blink phase toggles.
  - While blink_en=1 and phase=1: anode=4'hF, segment=8'hFF at each tick. Scan, idx and prescaler keep running.
  - blink_en=0 forces phase=0 and round count=0; the display returns at the next tick.
- Simultaneous load + blink phase 1: the shadow updates but stays invisible until phase returns to 0.
- Reset mid-scan: outputs blank immediately, without waiting for clk; state returns to OFF and a new load is required.
- Exactly one anode bit is ever 0, or none.

Decomposition:
- Shared package `seg7_pkg`:
  - 16-entry HEX_SEG table (7-bit, active-low).
  - Constants SEG_BLANK=8'hFF and AN_OFF=4'hF.
  - State encoding enum {OFF, RUN}.
- One combinational sub-module `hex7seg`: 4-bit nibble plus dp → 8-bit segment byte.
- Scan, blink, blanking and the FSM live in the top module.

Test Plan (SCAN_CNT=4, BLINK_ROUNDS=2):
- Reset check: rst=0 mid-run → segment=FF, anode=F, active=0 with no clk edge. Release rst, idle 40 cycles without load → outputs stay FF/F.
- Scan order: load with disp_num=16'h12AF, dp_in=0, blank_lz=0 → 4 cycles later anode=1110/seg=8E, then 1101/88, 1011/A4, 0111/F9, each held exactly 4 cycles, repeating.
- Leading-zero blanking: blank_lz=1 with value 16'h0030 → slots show 1110/C0, 1101/B0, then F/FF for digits 2 and 3. Value 16'h0000 → only digit 0 shows C0.
- Decimal point and mid-slot load:
  - dp_in=4'b0100 with 16'h12AF → the digit-2 slot shows segment=24.
  - Load 16'h0000 two cycles into a slot → the current slot is unchanged, the next slot shows the new value.
- Blink:
  - blink_en=1 → 2 visible rounds (32 cycles), then 32 cycles of anode=F while idx keeps advancing, then visible again.
  - Drop blink_en while blanked → digits visible at the next tick.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, segment table and state encoding for the 7-segment scanner
package seg7_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value (0 at the right end)
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef enum logic {OFF, RUN} state_t;

endpackage

// File: rtl/hex7seg.sv
// hex7seg: nibble plus decimal point to active-low segment byte
// Ports: i_nib  - hex digit value
//        i_dp   - decimal point, active-high
//        o_seg  - {dp,g,f,e,d,c,b,a}, active-low
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    assign o_seg = {~i_dp, HEX_SEG[i_nib]};

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: 4-digit multiplexed 7-segment driver with shadow load, blanking and blink
// Ports: clk       - system clock
//        rst       - asynchronous reset, active-low
//        disp_num  - value to show, nibble k on digit k (digit 0 rightmost)
//        load      - strobe capturing disp_num, blank_lz and dp_in
//        blank_lz  - leading-zero blanking enable
//        dp_in     - per-digit decimal points, active-high
//        blink_en  - blink the whole display
//        segment   - {dp,g,f,e,d,c,b,a}, active-low, registered
//        anode     - digit enables, active-low, registered
//        active    - high once the first load has started scanning
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_CNT     = 50000,
    parameter int BLINK_ROUNDS = 64
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] disp_num,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_in,
    input  logic        blink_en,
    output logic [7:0]  segment,
    output logic [3:0]  anode,
    output logic        active
);

    localparam int PW = $clog2(SCAN_CNT);
    localparam int RW = $clog2(BLINK_ROUNDS + 1);

    state_t          r_state, w_state;
    logic [15:0]     r_val, w_val;
    logic [3:0]      r_dp, w_dp;
    logic            r_blz, w_blz;
    logic [PW-1:0]   r_pre, w_pre;
    logic [1:0]      r_idx, w_idx;
    logic [RW-1:0]   r_rnd, w_rnd;
    logic            r_phase, w_phase;
    logic [7:0]      r_seg, w_seg;
    logic [3:0]      r_an, w_an;

    logic [15:0]     w_sv;
    logic [3:0]      w_sdp;
    logic            w_sblz;
    logic [1:0]      w_nidx;
    logic [7:0]      w_dec;
    logic            w_lz;
    logic            w_tick;
    logic            w_blank;

    // Shadow contents as they will be after this edge, so a load coinciding
    // with a tick is decoded immediately
    assign w_sv   = load ? disp_num : r_val;
    assign w_sdp  = load ? dp_in : r_dp;
    assign w_sblz = load ? blank_lz : r_blz;
    assign w_nidx = r_idx + 2'd1;

    // Digit k is a leading zero when it and every higher nibble are zero
    assign w_lz   = w_sblz && (w_nidx != 2'd0) && ((w_sv >> {w_nidx, 2'b00}) == 16'd0);
    assign w_tick = (r_state == RUN) && (r_pre == PW'(SCAN_CNT - 1));

    hex7seg u_hex7seg (
        .i_nib (w_sv[{w_nidx, 2'b00} +: 4]),
        .i_dp  (w_sdp[w_nidx]),
        .o_seg (w_dec)
    );

    always_comb begin
        w_state = r_state;
        w_val   = w_sv;
        w_dp    = w_sdp;
        w_blz   = w_sblz;
        w_pre   = r_pre;
        w_idx   = r_idx;
        w_rnd   = r_rnd;
        w_phase = r_phase;
        w_seg   = r_seg;
        w_an    = r_an;
        w_blank = 1'b0;
        if (r_state == OFF) begin
            if (load) begin
                w_state = RUN;
                w_pre   = '0;
                w_idx   = 2'd3;
            end
        end else begin
            w_pre = w_tick ? '0 : r_pre + PW'(1);
            if (w_tick) begin
                w_idx = w_nidx;
                // One blink round ends each time the scan wraps back to digit 0
                if (r_idx == 2'd3) begin
                    if (r_rnd == RW'(BLINK_ROUNDS - 1)) begin
                        w_rnd   = '0;
                        w_phase = ~r_phase;
                    end else begin
                        w_rnd = r_rnd + RW'(1);
                    end
                end
            end
        end
        if (!blink_en) begin
            w_rnd   = '0;
            w_phase = 1'b0;
        end
        // Outputs only ever change on a tick, keeping each slot glitch-free
        if (w_tick) begin
            w_blank = w_lz || (blink_en && w_phase);
            w_seg   = w_blank ? SEG_BLANK : w_dec;
            w_an    = w_blank ? AN_OFF : ~(4'b0001 << w_nidx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= OFF;
            r_val   <= '0;
            r_dp    <= '0;
            r_blz   <= 1'b0;
            r_pre   <= '0;
            r_idx   <= 2'd3;
            r_rnd   <= '0;
            r_phase <= 1'b0;
            r_seg   <= SEG_BLANK;
            r_an    <= AN_OFF;
        end else begin
            r_state <= w_state;
            r_val   <= w_val;
            r_dp    <= w_dp;
            r_blz   <= w_blz;
            r_pre   <= w_pre;
            r_idx   <= w_idx;
            r_rnd   <= w_rnd;
            r_phase <= w_phase;
            r_seg   <= w_seg;
            r_an    <= w_an;
        end
    end

    assign segment = r_seg;
    assign anode   = r_an;
    assign active  = (r_state == RUN);

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed bench for the scanner with SCAN_CNT=4, BLINK_ROUNDS=2
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] disp_num = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp_in = '0;
    logic        blink_en = 1'b0;
    logic [7:0]  segment;
    logic [3:0]  anode;
    logic        active;

    int checks = 0;
    int errors = 0;

    seg7_scan_display #(.SCAN_CNT(4), .BLINK_ROUNDS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .disp_num (disp_num),
        .load     (load),
        .blank_lz (blank_lz),
        .dp_in    (dp_in),
        .blink_en (blink_en),
        .segment  (segment),
        .anode    (anode),
        .active   (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an, input logic [7:0] sg);
        chk({tag, "_an"}, {4'h0, anode}, {4'h0, an});
        chk({tag, "_seg"}, segment, sg);
    endtask

    task automatic slot(input string tag, input logic [3:0] an, input logic [7:0] sg, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_out(tag, an, sg);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic blz);
        disp_num = v;
        dp_in    = dp;
        blank_lz = blz;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Reset state and idle without load
        #1 rst = 1'b0;
        #1;
        chk_out("rst0", 4'hF, 8'hFF);
        chk("rst0_active", {7'd0, active}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk_out("idle", 4'hF, 8'hFF);
        chk("idle_active", {7'd0, active}, 8'd0);

        // Scan order on 12AF
        do_load(16'h12AF, 4'b0000, 1'b0);
        chk("load_active", {7'd0, active}, 8'd1);
        slot("pre_first", 4'hF, 8'hFF, 3);
        slot("scan_d0", 4'b1110, 8'h8E, 4);
        slot("scan_d1", 4'b1101, 8'h88, 4);
        slot("scan_d2", 4'b1011, 8'hA4, 4);
        slot("scan_d3", 4'b0111, 8'hF9, 4);
        slot("scan_d0b", 4'b1110, 8'h8E, 4);
        slot("scan_d1b", 4'b1101, 8'h88, 2);

        // Asynchronous reset mid-slot, then no scan until a new load
        rst = 1'b0;
        #1;
        chk_out("async_rst", 4'hF, 8'hFF);
        chk("async_rst_active", {7'd0, active}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        slot("post_rst", 4'hF, 8'hFF, 6);
        chk("post_rst_active", {7'd0, active}, 8'd0);

        // Leading-zero blanking
        do_load(16'h0030, 4'b0000, 1'b1);
        slot("lz_wait", 4'hF, 8'hFF, 3);
        slot("lz_d0", 4'b1110, 8'hC0, 4);
        slot("lz_d1", 4'b1101, 8'hB0, 4);
        slot("lz_d2", 4'hF, 8'hFF, 4);
        slot("lz_d3", 4'hF, 8'hFF, 4);
        slot("lz_d0b", 4'b1110, 8'hC0, 4);
        // Load coinciding with the tick into digit 1 takes effect on that tick
        do_load(16'h0000, 4'b0000, 1'b1);
        chk_out("lz0_d1_tick", 4'hF, 8'hFF);
        slot("lz0_d1", 4'hF, 8'hFF, 3);
        slot("lz0_d2", 4'hF, 8'hFF, 4);
        slot("lz0_d3", 4'hF, 8'hFF, 4);
        slot("lz0_d0", 4'b1110, 8'hC0, 4);

        // Decimal point and mid-slot load
        pulse_rst();
        do_load(16'h12AF, 4'b0100, 1'b0);
        slot("dp_wait", 4'hF, 8'hFF, 3);
        slot("dp_d0", 4'b1110, 8'h8E, 4);
        slot("dp_d1", 4'b1101, 8'h88, 4);
        slot("dp_d2", 4'b1011, 8'h24, 4);
        slot("dp_d3", 4'b0111, 8'hF9, 4);
        slot("mid_d0", 4'b1110, 8'h8E, 2);
        do_load(16'h0000, 4'b0100, 1'b0);
        chk_out("mid_hold", 4'b1110, 8'h8E);
        slot("mid_hold2", 4'b1110, 8'h8E, 1);
        slot("mid_d1", 4'b1101, 8'hC0, 4);
        slot("mid_d2", 4'b1011, 8'h40, 1);

        // Blink: 32 visible cycles, 32 blank, visible again
        pulse_rst();
        do_load(16'h12AF, 4'b0000, 1'b0);
        slot("bl_wait", 4'hF, 8'hFF, 3);
        slot("bl_d0", 4'b1110, 8'h8E, 1);
        blink_en = 1'b1;
        slot("bl_d0", 4'b1110, 8'h8E, 3);
        slot("bl_d1", 4'b1101, 8'h88, 4);
        slot("bl_d2", 4'b1011, 8'hA4, 4);
        slot("bl_d3", 4'b0111, 8'hF9, 4);
        slot("bl_r2d0", 4'b1110, 8'h8E, 4);
        slot("bl_r2d1", 4'b1101, 8'h88, 4);
        slot("bl_r2d2", 4'b1011, 8'hA4, 4);
        slot("bl_r2d3", 4'b0111, 8'hF9, 4);
        slot("bl_off", 4'hF, 8'hFF, 32);
        slot("bl_on_d0", 4'b1110, 8'h8E, 4);
        slot("bl_on_d1", 4'b1101, 8'h88, 4);
        slot("bl_on_d2", 4'b1011, 8'hA4, 4);
        slot("bl_on_d3", 4'b0111, 8'hF9, 4);
        slot("bl_on_d0b", 4'b1110, 8'h8E, 4);
        slot("bl_on_d1b", 4'b1101, 8'h88, 4);
        slot("bl_on_d2b", 4'b1011, 8'hA4, 4);
        slot("bl_on_d3b", 4'b0111, 8'hF9, 4);
        slot("bl_off2_d0", 4'hF, 8'hFF, 4);
        slot("bl_off2_d1", 4'hF, 8'hFF, 2);
        // Dropping blink mid-slot holds the blank slot until the next tick
        blink_en = 1'b0;
        slot("bl_drop_hold", 4'hF, 8'hFF, 2);
        slot("bl_drop_d2", 4'b1011, 8'hA4, 4);
        slot("bl_drop_d3", 4'b0111, 8'hF9, 1);
        chk("bl_active", {7'd0, active}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
